// File: rtl/rover_sw_debounce.sv
// rover_sw_debounce
//
// Four-channel slide-switch conditioner that sits in front of the switch PIO in_port.
// Each raw asynchronous switch line goes through a two-flop synchroniser.
// A per-channel stability counter then filters contact bounce.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive clock edges in which
// the synchronised input disagrees with the current debounced level.
// Any agreement in between clears the count, so separate glitches never accumulate.
//
// Parameters:
//   WIDTH           number of switch channels
//   CNT_W           width of each per-channel stability counter
//   DEBOUNCE_CYCLES edges of disagreement needed to accept a level (1 .. 2**CNT_W-1)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   raw_in     raw switch levels, asynchronous to clk
//   sw_out     debounced levels (to PIO in_port)
//   rise_pulse one-cycle pulse in the first cycle a sw_out bit reads 1 after being 0
//   fall_pulse one-cycle pulse in the first cycle a sw_out bit reads 0 after being 1
//   stable     high when every synchronised input equals its sw_out bit

module rover_sw_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             stable
);

    // Terminal count: reaching it with a mismatch accepts the new level.
    // The counter is cleared at that point, so it can never wrap.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            s1_q;
    logic [WIDTH-1:0]            s2_q;
    logic [WIDTH-1:0]            sw_q,   sw_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q,  cnt_d;

    // Plain two-flop synchroniser, nothing between the stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw_in;
            s2_q <= s1_q;
        end
    end

    // Per-channel debounce: agreement clears the count.
    // A full run of disagreement accepts the synchronised level.
    always_comb begin
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] != sw_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    sw_d[i]   = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
        end else begin
            sw_q   <= sw_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sw_out     = sw_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign stable     = &(~(s2_q ^ sw_q));

endmodule

// File: tb/tb_rover_sw_debounce.sv
// Testbench for rover_sw_debounce.
// dut runs with DEBOUNCE_CYCLES=8 and dut1 with DEBOUNCE_CYCLES=1, both with CNT_W=4.
// The reference model keeps the history of raw samples taken at each clock edge.
// A channel accepts a new level when the synchronised samples (two edges old) seen over
// the last DEBOUNCE_CYCLES edges all differ from the current debounced level.

module tb_rover_sw_debounce;

    localparam int unsigned W   = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned DC  = 8;
    localparam int unsigned DC1 = 1;

    typedef logic [W-1:0] vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    vec_t raw     = '0;
    vec_t raw1    = '0;
    vec_t sw, rise, fall, sw1, rise1, fall1;
    logic stb, stb1;

    rover_sw_debounce #(
        .WIDTH          (W),
        .CNT_W          (CW),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (raw),
        .sw_out    (sw),
        .rise_pulse(rise),
        .fall_pulse(fall),
        .stable    (stb)
    );

    rover_sw_debounce #(
        .WIDTH          (W),
        .CNT_W          (CW),
        .DEBOUNCE_CYCLES(DC1)
    ) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (raw1),
        .sw_out    (sw1),
        .rise_pulse(rise1),
        .fall_pulse(fall1),
        .stable    (stb1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: raw sample history (newest first) and expected outputs.
    vec_t hist0[$];
    vec_t hist1[$];
    vec_t m_sw0, m_rise0, m_fall0;
    vec_t m_sw1, m_rise1, m_fall1;

    // Channels whose last dc synchronised samples all disagree with sw.
    function automatic vec_t accept_mask(input vec_t h[$], input int dc, input vec_t sw_now);
        vec_t m = '1;
        for (int k = 1; k <= dc; k++) m &= h[k] ^ sw_now;
        return m;
    endfunction

    task automatic model_reset();
        hist0 = {};
        hist1 = {};
        for (int k = 0; k <= int'(DC); k++)  hist0.push_back('0);
        for (int k = 0; k <= int'(DC1); k++) hist1.push_back('0);
        m_sw0 = '0; m_rise0 = '0; m_fall0 = '0;
        m_sw1 = '0; m_rise1 = '0; m_fall1 = '0;
    endtask

    // One clock edge: advance the model, then compare every output 1 time unit later.
    task automatic step();
        vec_t a;
        @(posedge clk);
        a       = accept_mask(hist0, int'(DC), m_sw0);
        m_rise0 = a & hist0[1];
        m_fall0 = a & ~hist0[1];
        m_sw0   = (m_sw0 & ~a) | (hist0[1] & a);
        hist0.push_front(raw);
        void'(hist0.pop_back());
        a       = accept_mask(hist1, int'(DC1), m_sw1);
        m_rise1 = a & hist1[1];
        m_fall1 = a & ~hist1[1];
        m_sw1   = (m_sw1 & ~a) | (hist1[1] & a);
        hist1.push_front(raw1);
        void'(hist1.pop_back());
        #1;
        check_eq("sw_out",      32'(sw),    32'(m_sw0));
        check_eq("rise_pulse",  32'(rise),  32'(m_rise0));
        check_eq("fall_pulse",  32'(fall),  32'(m_fall0));
        check_eq("stable",      32'(stb),   32'(&(~(hist0[1] ^ m_sw0))));
        check_eq("sw_out_1",    32'(sw1),   32'(m_sw1));
        check_eq("rise_pulse_1", 32'(rise1), 32'(m_rise1));
        check_eq("fall_pulse_1", 32'(fall1), 32'(m_fall1));
        check_eq("stable_1",    32'(stb1),  32'(&(~(hist1[1] ^ m_sw1))));
    endtask

    // Assert reset between edges, check the immediate effect, hold over an edge, release.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_sw_out",   32'(sw),   32'h0);
        check_eq("rst_rise",     32'(rise), 32'h0);
        check_eq("rst_fall",     32'(fall), 32'h0);
        check_eq("rst_stable",   32'(stb),  32'h1);
        check_eq("rst_sw_out_1", 32'(sw1),  32'h0);
        check_eq("rst_stable_1", 32'(stb1), 32'h1);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    int lat, rises, falls, lows;

    initial begin
        #1;
        do_reset();

        // Clean step on channel 0.
        raw[0] = 1'b1;
        lat = 0; rises = 0; lows = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (!stb) lows++;
            if (rise[0]) rises++;
            if (sw[0] && lat == 0) lat = e;
        end
        check_eq("clean_latency", 32'(lat),   32'd10);
        check_eq("clean_rises",   32'(rises), 32'd1);
        check_eq("clean_unstable", 32'(lows), 32'd8);

        // Bounce on channel 1: 1,0,1,0 for 3 cycles each, then hold 1.
        rises = 0;
        for (int p = 0; p < 4; p++) begin
            raw[1] = (p % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                step();
                if (rise[1]) rises++;
            end
        end
        check_eq("bounce_no_early", 32'(sw[1]), 32'h0);
        raw[1] = 1'b1;
        lat = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (rise[1]) rises++;
            if (sw[1] && lat == 0) lat = e;
        end
        check_eq("bounce_latency", 32'(lat),   32'd10);
        check_eq("bounce_rises",   32'(rises), 32'd1);

        // Short glitch on channel 2: high for 7 cycles only.
        rises = 0; falls = 0;
        raw[2] = 1'b1;
        for (int k = 0; k < 22; k++) begin
            if (k == 7) raw[2] = 1'b0;
            step();
            if (rise[2]) rises++;
            if (fall[2]) falls++;
            if (sw[2]) lat = 99;
        end
        check_eq("glitch_sw",     32'(sw[2]), 32'h0);
        check_eq("glitch_pulses", 32'(rises + falls), 32'd0);
        check_eq("glitch_cnt",    32'(dut.cnt_q[2]), 32'h0);

        // Multi-channel: 0000 -> 1111, then 1111 -> 0101.
        raw = '0;
        settle(14);
        raw = 4'hF;
        lat = 0;
        for (int e = 1; e <= 20 && lat == 0; e++) begin
            step();
            if (rise != '0) begin
                lat = e;
                check_eq("multi_rise", 32'(rise), 32'hF);
                check_eq("multi_sw",   32'(sw),   32'hF);
            end
        end
        check_eq("multi_rise_lat", 32'(lat), 32'd10);
        step();
        check_eq("multi_rise_once", 32'(rise), 32'h0);
        raw = 4'h5;
        lat = 0;
        for (int e = 1; e <= 20 && lat == 0; e++) begin
            step();
            if (fall != '0) begin
                lat = e;
                check_eq("multi_fall", 32'(fall), 32'hA);
            end
        end
        check_eq("multi_fall_lat", 32'(lat), 32'd10);

        // Reset five cycles into a 0->1 transition on channel 0.
        raw = '0;
        settle(14);
        raw = 4'h1;
        settle(5);
        do_reset();
        lat = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (sw[0] && lat == 0) lat = e;
        end
        check_eq("reset_relatency", 32'(lat), 32'd10);

        // DEBOUNCE_CYCLES=1: a single-cycle raw pulse on dut1.
        raw1 = '0;
        settle(4);
        raw1[0] = 1'b1;
        lat = 0; rises = 0; falls = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            raw1[0] = 1'b0;
            if (rise1[0]) rises++;
            if (fall1[0]) falls++;
            if (sw1[0] && lat == 0) lat = e;
        end
        check_eq("dc1_latency", 32'(lat),   32'd3);
        check_eq("dc1_rises",   32'(rises), 32'd1);
        check_eq("dc1_falls",   32'(falls), 32'd1);

        // Randomised phase against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < int'(W); i++) begin
                if ($urandom_range(11) == 0) raw[i] = ~raw[i];
            end
            raw1 = vec_t'($urandom);
            if ($urandom_range(499) == 0) do_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
